uart_bist_ctrl: RTL and testbench
=================================

// Module: uart_bist_ctrl
// PURPOSE
//  BIST sequencer for the UART loopback: LFSR -> UART_TX -> UART_RX, with TX and RX SAR signatures.
//  On i_Start it drives mode=1 and issues NUM_BYTES one-cycle TX strobes, one per completed RX byte.
//  It watchdogs every byte, then compares the TX/RX SAR signatures and reports pass/fail/timeout.
//  Sits in the UART top level beside the datapath; it owns o_Mode and the TX_DV strobe while o_Busy=1.
// PARAMETERS
//  NUM_BYTES      16    bytes per BIST run (1..255)
//  TIMEOUT_CYCLES 4096  max clocks from TX strobe to RX_DV (one frame at 25MHz/115200 ~ 2170)
//  SAR_WIDTH      16    width of compared signatures
// PORTS
//  i_Clock       in   1          system clock
//  i_Rst_L       in   1          reset, asynchronous, active-low
//  i_Start       in   1          level/pulse; sampled only in IDLE
//  i_Abort       in   1          synchronous abort, any state
//  i_TX_Active   in   1          UART_TX busy flag
//  i_RX_DV       in   1          UART_RX byte-valid pulse
//  i_SAR_Tx      in   SAR_WIDTH  TX-side signature
//  i_SAR_Rx      in   SAR_WIDTH  RX-side signature
//  o_Mode        out  1          1 = LFSR data selected (high while o_Busy)
//  o_TX_DV       out  1          one-cycle TX strobe (also LFSR/SAR_TX enable)
//  o_Busy        out  1          run in progress
//  o_Done        out  1          one-cycle pulse at run end (not on abort)
//  o_Status      out  2          00 none, 01 pass, 10 signature mismatch, 11 timeout
//  o_Byte_Count  out  8          bytes received this run
// BEHAVIOUR
//  Reset (i_Rst_L=0, async): state=IDLE; all outputs 0.
//  States: IDLE, SEND, WAIT_RX, WAIT_TX, SETTLE, CHECK, DONE.
//  IDLE:    i_Start=1 -> SEND; clear o_Byte_Count, o_Status, timer; o_Mode=1, o_Busy=1 from next cycle.
//  SEND:    o_TX_DV=1 for exactly one cycle -> WAIT_RX; timer cleared.
//  WAIT_RX: timer++ each cycle. i_RX_DV -> o_Byte_Count++ then WAIT_TX.
//           Timer reaching TIMEOUT_CYCLES-1 without RX_DV -> DONE with o_Status=11.
//           i_RX_DV on the same cycle the timer expires: the byte wins (no timeout).
//  WAIT_TX: hold until i_TX_Active=0 (stop bit finished).
//           Then count==NUM_BYTES -> SETTLE, else -> SEND.
//           Min one cycle here, so o_TX_DV pulses are never back-to-back.
//  SETTLE:  one cycle, lets the RX SAR absorb the last byte -> CHECK.
//  CHECK:   i_SAR_Tx==i_SAR_Rx -> o_Status=01 else 10 -> DONE.
//  DONE:    o_Done=1 one cycle; o_Busy, o_Mode drop next cycle -> IDLE.
//           o_Status, o_Byte_Count hold until next start.
//  i_Abort: -> IDLE next cycle from any state; o_TX_DV forced 0; o_Status=00; no o_Done.
//           Takes priority over every other transition.
//  i_Start while busy: ignored. i_Start held high: a new run starts one cycle after DONE.
//  Stray i_RX_DV outside WAIT_RX: ignored, count unchanged.
//  Timer width: $clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
//  Byte count 8 bits; NUM_BYTES<=255 so it never wraps.
//  o_TX_DV is registered; latency i_Start -> first o_TX_DV = 2 cycles.
// STRUCTURE
//  Shared package uart_bist_pkg: state encoding (localparam/enum), STATUS_NONE/PASS/SIG_FAIL/TIMEOUT codes.
//  One sub-module: bist_watchdog (load/enable/expire counter, parameterised by TIMEOUT_CYCLES).
//  FSM, byte counter, status register in this module.
//  Top level: o_Mode drives the data mux select; o_TX_DV drives UART_TX, LFSR and SAR_TX enables.
// TESTING
//  T1 loopback NUM_BYTES=4, start pulse -> 4 TX strobes, o_Byte_Count=4, o_Done pulse, o_Status=01.
//  T2 RX model corrupts byte 2 (XOR 0x01) -> o_Byte_Count=4, o_Status=10.
//  T3 RX_DV suppressed for byte 3 -> o_Status=11 exactly TIMEOUT_CYCLES after 3rd strobe, o_Byte_Count=2.
//  T4 i_Abort mid byte 2 -> IDLE next cycle, o_Busy=0, o_Status=00, no o_Done, no further strobes.
//  T5 i_Start held high for 2 runs, plus stray RX_DV in IDLE -> two back-to-back runs both 01, count unaffected.
//  T6 i_Rst_L low during WAIT_RX, asynchronous to the clock -> all outputs 0 immediately; restart passes with 01.

Source files
------------

// File: rtl/uart_bist_pkg.sv
// Shared types and codes for the UART loopback BIST sequencer.
package uart_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } bist_state_t;

  localparam logic [1:0] STATUS_NONE     = 2'b00;
  localparam logic [1:0] STATUS_PASS     = 2'b01;
  localparam logic [1:0] STATUS_SIG_FAIL = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b11;

  // One spare bit so the watchdog can saturate above its expiry value.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/uart_bist_ctrl_if.sv
// Control/status bundle between the BIST sequencer and the UART datapath.
interface uart_bist_ctrl_if #(
  parameter int unsigned SAR_WIDTH = 16
);
  import uart_bist_pkg::*;

  // o_TX_DV is a one-cycle strobe with no ready: UART_TX takes the byte on the
  // strobe and reports its own progress on i_TX_Active; i_RX_DV is a one-cycle
  // byte-valid pulse that the sequencer consumes only while waiting for a byte.
  logic                 i_Start;
  logic                 i_Abort;
  logic                 i_TX_Active;
  logic                 i_RX_DV;
  logic [SAR_WIDTH-1:0] i_SAR_Tx;
  logic [SAR_WIDTH-1:0] i_SAR_Rx;
  logic                 o_Mode;
  logic                 o_TX_DV;
  logic                 o_Busy;
  logic                 o_Done;
  logic [1:0]           o_Status;
  logic [7:0]           o_Byte_Count;
  bist_state_t          o_Dbg_State;

  modport slave (
    input  i_Start, i_Abort, i_TX_Active, i_RX_DV, i_SAR_Tx, i_SAR_Rx,
    output o_Mode, o_TX_DV, o_Busy, o_Done, o_Status, o_Byte_Count, o_Dbg_State
  );

  modport master (
    output i_Start, i_Abort, i_TX_Active, i_RX_DV, i_SAR_Tx, i_SAR_Rx,
    input  o_Mode, o_TX_DV, o_Busy, o_Done, o_Status, o_Byte_Count, o_Dbg_State
  );

endinterface

// File: rtl/bist_watchdog.sv
// Per-byte watchdog: cleared by load, counts while enabled, saturates, flags expiry.
module bist_watchdog
  import uart_bist_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Load,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int unsigned W = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST_COUNT = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX_COUNT  = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = '0;
    end else if (i_Enable && (count_q != MAX_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Expire = (count_q >= LAST_COUNT);

endmodule

// File: rtl/uart_bist_ctrl.sv
// BIST sequencer for LFSR -> UART_TX -> UART_RX loopback with SAR signature compare.
module uart_bist_ctrl
  import uart_bist_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned SAR_WIDTH      = 16
) (
  input  logic           i_Clock,
  input  logic           i_Rst_L,
  uart_bist_ctrl_if.slave bus
);

  localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES);

  bist_state_t state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  status_q, status_d;
  logic        tx_dv_q, tx_dv_d;
  logic        wd_expire;
  logic        sar_match;

  assign sar_match = (SAR_WIDTH'(bus.i_SAR_Tx) == SAR_WIDTH'(bus.i_SAR_Rx));

  // The timer only runs while a byte is outstanding; every other state holds it clear.
  bist_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Load  (state_q != ST_WAIT_RX),
    .i_Enable(state_q == ST_WAIT_RX),
    .o_Expire(wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    status_d = status_q;
    tx_dv_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          state_d  = ST_SEND;
          count_d  = '0;
          status_d = STATUS_NONE;
        end
      end
      ST_SEND: begin
        tx_dv_d = 1'b1;
        state_d = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        // A byte arriving on the expiry cycle still counts as received.
        if (bus.i_RX_DV) begin
          count_d = count_q + 8'd1;
          state_d = ST_WAIT_TX;
        end else if (wd_expire) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_DONE;
        end
      end
      ST_WAIT_TX: begin
        if (!bus.i_TX_Active) begin
          state_d = (count_q == LAST_BYTE) ? ST_SETTLE : ST_SEND;
        end
      end
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        status_d = sar_match ? STATUS_PASS : STATUS_SIG_FAIL;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.i_Abort) begin
      state_d  = ST_IDLE;
      tx_dv_d  = 1'b0;
      status_d = STATUS_NONE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      status_q <= STATUS_NONE;
      tx_dv_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      status_q <= status_d;
      tx_dv_q  <= tx_dv_d;
    end
  end

  assign bus.o_Busy       = (state_q != ST_IDLE);
  assign bus.o_Mode       = (state_q != ST_IDLE);
  assign bus.o_Done       = (state_q == ST_DONE);
  assign bus.o_TX_DV      = tx_dv_q;
  assign bus.o_Status     = status_q;
  assign bus.o_Byte_Count = count_q;
  assign bus.o_Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_bist_ctrl.sv
// Bench for uart_bist_ctrl: randomized UART loopback model, signature model, outcome scoreboard.
module tb_uart_bist_ctrl;
  import uart_bist_pkg::*;

  localparam int NUM      = 4;
  localparam int TIMEOUT  = 64;
  localparam int SAR_W    = 16;
  localparam int BOUND    = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_bist_ctrl_if #(.SAR_WIDTH(SAR_W)) bus ();

  uart_bist_ctrl #(
    .NUM_BYTES(NUM), .TIMEOUT_CYCLES(TIMEOUT), .SAR_WIDTH(SAR_W)
  ) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  // ---------------- model state ----------------
  logic             model_rx_dv = 1'b0;
  logic             stray_rx_dv = 1'b0;
  logic [SAR_W-1:0] sar_tx = '0;
  logic [SAR_W-1:0] sar_rx = '0;
  assign bus.i_RX_DV    = model_rx_dv | stray_rx_dv;
  assign bus.i_SAR_Tx   = sar_tx;
  assign bus.i_SAR_Rx   = sar_rx;

  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];
  int         strobe_cyc_q[$];
  int         done_cyc_q[$];
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int done_cnt = 0, b2b_cnt = 0, byte_in_run = 0;
  int drop_idx = 0, corrupt_idx = 0;
  int n_checks = 0, n_fail = 0;

  // Rotate-and-xor fold: any single-bit difference in one byte changes the result.
  function automatic logic [SAR_W-1:0] sig_of(input logic [7:0] q[$]);
    logic [SAR_W-1:0] s = '0;
    foreach (q[i]) s = {s[SAR_W-2:0], s[SAR_W-1]} ^ SAR_W'(q[i]);
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART loopback: each strobe starts a frame; the RX byte lands near the frame end.
  initial begin : uart_model
    int k, frame_len, rx_at;
    logic drop_this, prev_tx_dv;
    logic [7:0] cur_b;
    k = 0; frame_len = 0; rx_at = 0; drop_this = 1'b0; prev_tx_dv = 1'b0; cur_b = '0;
    bus.i_TX_Active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0; model_rx_dv = 1'b0; bus.i_TX_Active = 1'b0; prev_tx_dv = 1'b0;
      end else begin
        model_rx_dv = 1'b0;
        if (bus.o_Done) begin
          done_cnt++;
          done_cyc_q.push_back(cyc);
          got_q.push_back({bus.o_Byte_Count, bus.o_Status});
          byte_in_run = 0;
        end
        if (bus.o_TX_DV) begin
          if (prev_tx_dv) b2b_cnt++;
          strobe_cyc_q.push_back(cyc);
          byte_in_run++;
          cur_b = 8'($urandom_range(0, 255));
          tx_bytes.push_back(cur_b);
          sar_tx = sig_of(tx_bytes);
          if (byte_in_run == corrupt_idx) cur_b = cur_b ^ 8'h01;
          drop_this = (byte_in_run == drop_idx);
          frame_len = $urandom_range(3, 12);
          rx_at = frame_len - $urandom_range(0, 1);
          k = 0;
          bus.i_TX_Active = 1'b1;
        end else if (bus.i_TX_Active) begin
          k++;
          if (k == rx_at && !drop_this) begin
            model_rx_dv = 1'b1;
            rx_bytes.push_back(cur_b);
            sar_rx = sig_of(rx_bytes);
          end
          if (k == frame_len) bus.i_TX_Active = 1'b0;
        end
        prev_tx_dv = bus.o_TX_DV;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    strobe_cyc_q.delete(); done_cyc_q.delete(); got_q.delete(); exp_q.delete();
    tx_bytes.delete(); rx_bytes.delete();
    sar_tx = '0; sar_rx = '0;
    done_cnt = 0; b2b_cnt = 0; byte_in_run = 0;
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < BOUND; i++) begin
      if (done_cnt >= n) break;
      tick();
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt >= n), 1);
  endtask

  task automatic wait_strobes(input int n, input string tag);
    for (int i = 0; i < BOUND; i++) begin
      if (strobe_cyc_q.size() >= n) break;
      tick();
    end
    check_eq({tag, "_strobe_seen"}, 32'(strobe_cyc_q.size() >= n), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"},   32'(bus.o_Busy), 0);
    check_eq({tag, "_mode"},   32'(bus.o_Mode), 0);
    check_eq({tag, "_tx_dv"},  32'(bus.o_TX_DV), 0);
    check_eq({tag, "_done"},   32'(bus.o_Done), 0);
    check_eq({tag, "_status"}, 32'(bus.o_Status), 0);
    check_eq({tag, "_count"},  32'(bus.o_Byte_Count), 0);
  endtask

  task automatic score_runs(input string tag);
    logic [9:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'h3ff;
      check_eq({tag, "_count"},  32'(g[9:2]), 32'(e[9:2]));
      check_eq({tag, "_status"}, 32'(g[1:0]), 32'(e[1:0]));
    end
  endtask

  // One start pulse; outcome predicted from which byte is dropped or corrupted.
  task automatic run_one(input int drop, input int corrupt, input string tag);
    int start_cyc, exp_strobes, lat;
    logic [1:0] exp_status;
    clear_stats();
    drop_idx = drop; corrupt_idx = corrupt;
    exp_strobes = (drop != 0) ? drop : NUM;
    exp_status  = (drop != 0) ? STATUS_TIMEOUT : ((corrupt != 0) ? STATUS_SIG_FAIL : STATUS_PASS);
    exp_q.push_back({8'((drop != 0) ? drop - 1 : NUM), exp_status});
    bus.i_Start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.i_Start = 1'b0;
    wait_done(1, tag);
    repeat (3) tick();
    check_eq({tag, "_strobes"}, 32'(strobe_cyc_q.size()), 32'(exp_strobes));
    lat = (strobe_cyc_q.size() > 0) ? strobe_cyc_q[0] - start_cyc : -1;
    check_eq({tag, "_start_lat"}, 32'(lat), 2);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 1);
    check_eq({tag, "_back_to_back"}, 32'(b2b_cnt), 0);
    check_eq({tag, "_busy_after"}, 32'(bus.o_Busy), 0);
    check_eq({tag, "_status_held"}, 32'(bus.o_Status), 32'(exp_status));
    if (drop != 0) begin
      lat = (strobe_cyc_q.size() >= drop && done_cyc_q.size() > 0) ?
            done_cyc_q[0] - strobe_cyc_q[drop-1] : -1;
      check_eq({tag, "_timeout_lat"}, 32'(lat), 32'(TIMEOUT));
    end
    score_runs(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gap, d, c;
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    check_eq("reset_state", 32'(bus.o_Dbg_State), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) tick();

    run_one(0, 0, "t1_pass");
    run_one(0, 2, "t2_corrupt");
    run_one(3, 0, "t3_timeout");
    for (int r = 0; r < 3; r++) begin
      d = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NUM) : 0;
      c = $urandom_range(0, NUM);
      run_one(d, c, "rand");
    end

    // Abort while byte 2 is in flight, before its RX byte can arrive.
    clear_stats();
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    wait_strobes(2, "t4");
    bus.i_Abort = 1'b1;
    tick();
    bus.i_Abort = 1'b0;
    check_eq("t4_busy", 32'(bus.o_Busy), 0);
    check_eq("t4_mode", 32'(bus.o_Mode), 0);
    check_eq("t4_status", 32'(bus.o_Status), 0);
    check_eq("t4_state", 32'(bus.o_Dbg_State), 32'(ST_IDLE));
    repeat (40) tick();
    check_eq("t4_strobes", 32'(strobe_cyc_q.size()), 2);
    check_eq("t4_no_done", 32'(done_cnt), 0);
    check_eq("t4_count", 32'(bus.o_Byte_Count), 1);

    // Stray RX_DV in IDLE, then start held for two back-to-back runs.
    clear_stats();
    drop_idx = 0; corrupt_idx = 0;
    stray_rx_dv = 1'b1;
    tick();
    stray_rx_dv = 1'b0;
    tick();
    check_eq("t5_stray_count", 32'(bus.o_Byte_Count), 1);
    exp_q.push_back({8'(NUM), STATUS_PASS});
    exp_q.push_back({8'(NUM), STATUS_PASS});
    bus.i_Start = 1'b1;
    wait_done(1, "t5_run1");
    wait_strobes(NUM + 1, "t5_run2");
    bus.i_Start = 1'b0;
    wait_done(2, "t5_run2");
    repeat (5) tick();
    gap = (strobe_cyc_q.size() > NUM && done_cyc_q.size() > 0) ?
          strobe_cyc_q[NUM] - done_cyc_q[0] : -1;
    check_eq("t5_restart_gap", 32'(gap), 3);
    check_eq("t5_strobes", 32'(strobe_cyc_q.size()), 32'(2 * NUM));
    check_eq("t5_done_pulses", 32'(done_cnt), 2);
    check_eq("t5_back_to_back", 32'(b2b_cnt), 0);
    score_runs("t5");

    // Asynchronous reset mid-cycle while waiting for byte 3.
    clear_stats();
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    wait_strobes(3, "t6");
    check_eq("t6_count_before", 32'(bus.o_Byte_Count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_one(0, 0, "t6_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

endmodule
